// File: rtl/vga_line_fetch_if.sv
// vga_line_fetch_if: row fetch request/stream bus between the line fetcher (master) and frame memory (slave).
interface vga_line_fetch_if;
   logic        fetch_req;
   logic [7:0]  fetch_row;
   logic        pix_valid;
   logic [15:0] pix_data;
   modport master (output fetch_req, fetch_row, input pix_valid, pix_data);
   modport slave  (input fetch_req, fetch_row, output pix_valid, pix_data);
endinterface

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: prefetches 320x240 RGB565 rows into ping-pong line buffers and emits 2x-upscaled RGB888 with 2-cycle sync delay.
module vga_line_fetch #(
   parameter int SRC_W   = 320,
   parameter int SRC_H   = 240,
   parameter int V_TOTAL = 525
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic [12:0] i_hcnt,
   input  logic [12:0] i_vcnt,
   input  logic        i_visible_area,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic        i_underrun_clr,
   vga_line_fetch_if.master bus,
   output logic        o_underrun,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic        o_hsync,
   output logic        o_vsync
);
   typedef enum logic {IDLE, FETCH} state_t;
   state_t      r_state;
   logic [8:0]  r_cnt;
   logic [1:0]  r_buf_full;
   logic        r_fetch_req;
   logic [7:0]  r_fetch_row;
   logic        r_underrun;
   logic [15:0] r_mem [2][SRC_W];
   logic        r_vis, r_hs, r_vs, r_rd_buf;
   logic [8:0]  r_rd_addr;
   logic [7:0]  r_r, r_g, r_b;
   logic        r_hs_o, r_vs_o;
   logic        w_trig, w_wr, w_ur_set;
   logic [7:0]  w_row;
   logic [15:0] w_px;

   // Row r+1 is fetched at the start of display line 2r so it never lands in the buffer being shown.
   assign w_trig   = i_hcnt == '0 && (i_vcnt == 13'(V_TOTAL - 1) || (!i_vcnt[0] && i_vcnt <= 13'(2 * SRC_H - 4)));
   assign w_row    = i_vcnt == 13'(V_TOTAL - 1) ? 8'd0 : i_vcnt[8:1] + 8'd1;
   assign w_wr     = r_state == FETCH && bus.pix_valid && !w_trig;
   assign w_ur_set = (w_trig && r_state == FETCH) ||
                     (i_hcnt == '0 && i_vcnt < 13'(2 * SRC_H) && !r_buf_full[i_vcnt[1]]);

   always_ff @(posedge pixel_clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_buf_full  <= '0;
         r_fetch_req <= 1'b0;
         r_fetch_row <= '0;
         r_underrun  <= 1'b0;
      end else begin
         r_underrun <= w_ur_set | (r_underrun & ~i_underrun_clr);
         if (w_trig) begin
            r_state                <= FETCH;
            r_fetch_row            <= w_row;
            r_cnt                  <= '0;
            r_buf_full[w_row[0]]   <= 1'b0;
            r_fetch_req            <= 1'b1;
         end else if (w_wr) begin
            r_cnt <= r_cnt + 9'd1;
            if (r_cnt == 9'(SRC_W - 1)) begin
               r_state                    <= IDLE;
               r_fetch_req                <= 1'b0;
               r_buf_full[r_fetch_row[0]] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (w_wr) r_mem[r_fetch_row[0]][r_cnt] <= bus.pix_data;
   end

   assign w_px = r_mem[r_rd_buf][r_rd_addr];

   always_ff @(posedge pixel_clk or negedge rst) begin
      if (!rst) begin
         r_vis     <= 1'b0;
         r_hs      <= 1'b1;
         r_vs      <= 1'b1;
         r_rd_buf  <= 1'b0;
         r_rd_addr <= '0;
         r_r       <= '0;
         r_g       <= '0;
         r_b       <= '0;
         r_hs_o    <= 1'b1;
         r_vs_o    <= 1'b1;
      end else begin
         r_vis     <= i_visible_area;
         r_hs      <= i_hsync;
         r_vs      <= i_vsync;
         r_rd_buf  <= i_vcnt[1];
         r_rd_addr <= i_visible_area ? i_hcnt[9:1] : '0;
         r_r       <= r_vis ? {w_px[15:11], w_px[15:13]} : '0;
         r_g       <= r_vis ? {w_px[10:5], w_px[10:9]} : '0;
         r_b       <= r_vis ? {w_px[4:0], w_px[4:2]} : '0;
         r_hs_o    <= r_hs;
         r_vs_o    <= r_vs;
      end
   end

   assign bus.fetch_req = r_fetch_req;
   assign bus.fetch_row = r_fetch_row;
   assign o_underrun    = r_underrun;
   assign o_r           = r_r;
   assign o_g           = r_g;
   assign o_b           = r_b;
   assign o_hsync       = r_hs_o;
   assign o_vsync       = r_vs_o;
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: drives timing and a memory responder; a scoreboard queue checks every output pixel 2 cycles later.
module tb_vga_line_fetch;
   logic        pixel_clk = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] hcnt = '0, vcnt = '0;
   logic        vis = 1'b1, hs = 1'b1, vs = 1'b1, clr = 1'b0;
   logic        underrun, hso, vso;
   logic [7:0]  r, g, b;
   int          cyc = 0, checks = 0, fails = 0, mode = 0;

   typedef struct {int due; bit chk; logic [23:0] rgb; logic hs; logic vs;} exp_t;
   exp_t q[$];

   vga_line_fetch_if bus();

   vga_line_fetch dut (
      .pixel_clk(pixel_clk), .rst(rst), .i_hcnt(hcnt), .i_vcnt(vcnt),
      .i_visible_area(vis), .i_hsync(hs), .i_vsync(vs), .i_underrun_clr(clr),
      .bus(bus), .o_underrun(underrun), .o_r(r), .o_g(g), .o_b(b),
      .o_hsync(hso), .o_vsync(vso)
   );

   always #20 pixel_clk = ~pixel_clk;
   always @(posedge pixel_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [23:0] px(input int v, input int h);
      logic [15:0] w;
      w = 16'((v / 2) * 320 + h / 2);
      return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
   endfunction

   function automatic bit trig_line(input int v);
      return v == 524 || (v % 2 == 0 && v <= 476);
   endfunction

   function automatic int exp_row(input int v);
      return v == 524 ? 0 : v / 2 + 1;
   endfunction

   // Frame memory: mode 0 streams every cycle, 1 every other cycle, 2 withholds data.
   initial begin
      int cnt;
      int last;
      bit ph;
      cnt = 0; last = -1; ph = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_data  = '0;
      forever begin
         @(posedge pixel_clk);
         #2;
         if (!bus.fetch_req) begin
            cnt = 0; last = -1; bus.pix_valid = 1'b0;
         end else begin
            if (int'(bus.fetch_row) != last) begin
               cnt = 0; last = int'(bus.fetch_row); ph = 1'b1;
            end
            bus.pix_valid = (mode == 0 || (mode == 1 && ph)) && cnt < 320;
            bus.pix_data  = 16'(int'(bus.fetch_row) * 320 + cnt);
            if (bus.pix_valid) cnt++;
            ph = ~ph;
         end
      end
   end

   initial begin
      forever begin
         @(negedge pixel_clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk) check("rgb", {8'h0, r, g, b}, {8'h0, e.rgb});
            check("hsync_o", {31'h0, hso}, {31'h0, e.hs});
            check("vsync_o", {31'h0, vso}, {31'h0, e.vs});
         end
      end
   end

   task automatic line(input int v, input int n, input int m, input bit rgb_ok);
      for (int h = 0; h < n; h++) begin
         @(posedge pixel_clk);
         #1;
         if (h == 0) mode = m;
         hcnt = 13'(h);
         vcnt = 13'(v);
         vis  = h < 640 && v < 480;
         hs   = !(h >= 656 && h < 752);
         vs   = !(v >= 490 && v < 492);
         q.push_back(exp_t'{cyc + 2, rgb_ok, vis ? px(v, h) : 24'h0, hs, vs});
         if (h == 1 && trig_line(v)) begin
            check("fetch_req", {31'h0, bus.fetch_req}, 32'd1);
            check("fetch_row", {24'h0, bus.fetch_row}, 32'(exp_row(v)));
         end
         if (h == 1 && v < 10) check("no_underrun", {31'h0, underrun}, 32'd0);
         if (h == 700 && m == 1) check("toggle_done", {31'h0, bus.fetch_req}, 32'd0);
         if (v == 0 && h == 657) check("hsync_o_pre", {31'h0, hso}, 32'd1);
         if (v == 0 && h == 658) check("hsync_o_fall", {31'h0, hso}, 32'd0);
         if (v == 10 && h == 1) check("underrun_abort", {31'h0, underrun}, 32'd1);
         if (v == 14 && h == 100) begin
            check("underrun_held", {31'h0, underrun}, 32'd1);
            clr = 1'b1;
         end
         if (v == 14 && h == 101) begin
            check("underrun_clr", {31'h0, underrun}, 32'd0);
            clr = 1'b0;
         end
         if (v == 16 && h == 0) clr = 1'b1;
         if (v == 16 && h == 1) begin
            check("underrun_set_wins", {31'h0, underrun}, 32'd1);
            clr = 1'b0;
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge pixel_clk);
      #1;
      check("rst_fetch_req", {31'h0, bus.fetch_req}, 32'd0);
      check("rst_underrun", {31'h0, underrun}, 32'd0);
      check("rst_rgb", {8'h0, r, g, b}, 32'd0);
      check("rst_syncs", {30'h0, hso, vso}, 32'd3);
      @(negedge pixel_clk);
      rst = 1'b1;
      #1;
      check("rel_fetch_req", {31'h0, bus.fetch_req}, 32'd0);
      check("rel_underrun", {31'h0, underrun}, 32'd0);
      check("rel_rgb", {8'h0, r, g, b}, 32'd0);
      check("rel_syncs", {30'h0, hso, vso}, 32'd3);
      hcnt = 13'd799; vcnt = 13'd523; vis = 1'b0;
      line(524, 800, 0, 1'b1);
      line(0, 800, 0, 1'b1);
      line(1, 800, 0, 1'b1);
      for (int v = 2; v < 6; v++) line(v, 800, 1, 1'b1);
      line(6, 800, 0, 1'b1);
      line(7, 800, 0, 1'b1);
      line(8, 800, 2, 1'b1);
      line(9, 800, 2, 1'b1);
      line(10, 800, 0, 1'b0);
      line(11, 800, 0, 1'b0);
      line(12, 800, 0, 1'b1);
      line(13, 800, 0, 1'b1);
      line(14, 800, 2, 1'b1);
      line(15, 800, 2, 1'b1);
      line(16, 6, 2, 1'b0);
      #5;
      rst = 1'b0;
      #1;
      check("midrst_fetch_req", {31'h0, bus.fetch_req}, 32'd0);
      check("midrst_underrun", {31'h0, underrun}, 32'd0);
      @(negedge pixel_clk);
      rst = 1'b1;
      hcnt = 13'd799; vcnt = 13'd523; vis = 1'b0; hs = 1'b1; vs = 1'b1;
      line(524, 10, 0, 1'b1);
      repeat (4) @(posedge pixel_clk);
      #1;
      check("sb_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
